// File: rtl/sub_float64_sigs.sv
// Multi-cycle binary64 significand subtractor: |a| - |b| packed as a double.
// Pipeline: IDLE latches operands, S1 aligns and subtracts, S2 normalizes and
// rounds into the result register, S3 signals completion.
module sub_float64_sigs (
    input  logic        ap_clk,
    input  logic        ap_rst,
    input  logic        ap_start,
    output logic        ap_done,
    output logic        ap_idle,
    output logic        ap_ready,
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        zSign,
    output logic [63:0] ap_return,
    input  logic [21:0] working_key
);

    typedef enum logic [1:0] {S_IDLE, S_1, S_2, S_3} state_t;

    localparam logic [63:0] IMPLICIT = 64'h4000_0000_0000_0000;
    localparam logic [63:0] QUIET    = 64'h0008_0000_0000_0000;

    // Handshake: a request is accepted on the rising edge where the block is
    // in IDLE and ap_start is high; ap_done/ap_ready pulse together for one
    // cycle (S3) with ap_return valid; ap_return holds until the next S3.
    state_t state_q, state_d;

    logic [63:0]        a_q, b_q;
    logic               zsign_q;
    logic               spec_q;
    logic [63:0]        spec_val_q;
    logic [63:0]        zsig_q;
    logic signed [12:0] zexp_q;
    logic               zsgn_q;
    logic [63:0]        ap_return_q;

    // Shift right, OR-ing every bit shifted out into the LSB.
    function automatic logic [63:0] srj(input logic [63:0] x, input logic [12:0] n);
        logic [63:0] mask;
        mask = '0;
        if (n == 13'd0) begin
            srj = x;
        end else if (n < 13'd64) begin
            mask = ~(64'hFFFF_FFFF_FFFF_FFFF << n[5:0]);
            srj  = (x >> n[5:0]) | {63'd0, |(x & mask)};
        end else begin
            srj = {63'd0, |x};
        end
    endfunction

    // Count leading zeros; 64 for a zero input.
    function automatic logic [6:0] clz64(input logic [63:0] x);
        clz64 = 7'd64;
        for (int i = 0; i < 64; i++) begin
            if (x[i]) clz64 = 7'(63 - i);
        end
    endfunction

    // ---------------- stage 1: classify, align, subtract ----------------
    logic [10:0]        a_exp, b_exp;
    logic [63:0]        a_sig, b_sig, nan_val;
    logic signed [12:0] exp_diff;
    logic               b_nan;

    assign a_exp    = a_q[62:52];
    assign b_exp    = b_q[62:52];
    assign a_sig    = {2'b00, a_q[51:0], 10'd0};
    assign b_sig    = {2'b00, b_q[51:0], 10'd0};
    assign exp_diff = $signed({2'b00, a_exp}) - $signed({2'b00, b_exp});
    assign b_nan    = (b_exp == 11'h7FF) && (b_q[51:0] != 52'd0);
    assign nan_val  = b_nan ? (b_q | QUIET) : (a_q | QUIET);

    logic               s1_spec;
    logic [63:0]        s1_val, s1_sig, s1_small;
    logic signed [12:0] s1_exp;
    logic               s1_sign;
    logic [12:0]        s1_sh;

    // Special-case detection and aligned difference of the significands.
    always_comb begin
        s1_spec  = 1'b0;
        s1_val   = '0;
        s1_sig   = '0;
        s1_small = '0;
        s1_exp   = '0;
        s1_sign  = zsign_q;
        s1_sh    = '0;
        if (exp_diff > 13'sd0) begin
            if (a_exp == 11'h7FF) begin
                s1_spec = 1'b1;
                s1_val  = (a_sig != 64'd0) ? nan_val : a_q;
            end else begin
                if (b_exp != 11'd0) begin
                    s1_small = b_sig | IMPLICIT;
                    s1_sh    = $unsigned(exp_diff);
                end else begin
                    s1_small = b_sig;
                    s1_sh    = $unsigned(exp_diff - 13'sd1);
                end
                s1_sig = (a_sig | IMPLICIT) - srj(s1_small, s1_sh);
                s1_exp = $signed({2'b00, a_exp});
            end
        end else if (exp_diff < 13'sd0) begin
            if (b_exp == 11'h7FF) begin
                s1_spec = 1'b1;
                s1_val  = (b_sig != 64'd0) ? nan_val : {~zsign_q, 11'h7FF, 52'd0};
            end else begin
                if (a_exp != 11'd0) begin
                    s1_small = a_sig | IMPLICIT;
                    s1_sh    = $unsigned(-exp_diff);
                end else begin
                    s1_small = a_sig;
                    s1_sh    = $unsigned(-exp_diff - 13'sd1);
                end
                s1_sig  = (b_sig | IMPLICIT) - srj(s1_small, s1_sh);
                s1_exp  = $signed({2'b00, b_exp});
                s1_sign = ~zsign_q;
            end
        end else begin
            if (a_exp == 11'h7FF) begin
                s1_spec = 1'b1;
                s1_val  = ((a_sig | b_sig) != 64'd0) ? nan_val : 64'h7FFF_FFFF_FFFF_FFFF;
            end else begin
                // Subnormal pair: both behave as exponent 1 with no implicit bit.
                s1_exp = (a_exp == 11'd0) ? 13'sd1 : $signed({2'b00, a_exp});
                if (a_sig > b_sig) begin
                    s1_sig = a_sig - b_sig;
                end else if (b_sig > a_sig) begin
                    s1_sig  = b_sig - a_sig;
                    s1_sign = ~zsign_q;
                end else begin
                    s1_spec = 1'b1;
                    s1_val  = 64'd0;
                end
            end
        end
    end

    // ---------------- stage 2: normalize and round to nearest even ----------------
    logic [6:0]         nsh;
    logic [63:0]        norm_sig;
    logic signed [12:0] norm_exp;
    logic [63:0]        rsig, rnd, res, ap_return_d;
    logic [12:0]        rexp;

    assign nsh      = clz64(zsig_q) - 7'd1;
    assign norm_sig = zsig_q << nsh[5:0];
    assign norm_exp = zexp_q - 13'sd1 - $signed({6'd0, nsh});

    // Overflow/underflow handling, rounding and final packing.
    always_comb begin
        rsig = '0;
        rnd  = '0;
        rexp = '0;
        res  = '0;
        if (norm_exp > 13'sd2045 || (norm_exp == 13'sd2045 && (&norm_sig[62:9]))) begin
            res = {zsgn_q, 11'h7FF, 52'd0};
        end else begin
            if (norm_exp < 13'sd0) begin
                rsig = srj(norm_sig, $unsigned(-norm_exp));
                rexp = 13'd0;
            end else begin
                rsig = norm_sig;
                rexp = $unsigned(norm_exp);
            end
            rnd = (rsig + 64'h200) >> 10;
            if (rsig[9:0] == 10'h200) rnd[0] = 1'b0;
            if (rnd == 64'd0) rexp = 13'd0;
            // Addition lets a mantissa carry bump the exponent.
            res = {zsgn_q, 63'd0} + ({51'd0, rexp} << 52) + rnd;
        end
        ap_return_d = (spec_q ? spec_val_q : res) ^ {42'd0, working_key};
    end

    // ---------------- control ----------------
    // Next-state logic for the fixed-latency sequence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (ap_start) state_d = S_1;
            S_1:     state_d = S_2;
            S_2:     state_d = S_3;
            S_3:     state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign ap_done   = (state_q == S_3);
    assign ap_ready  = (state_q == S_3);
    assign ap_idle   = (state_q == S_IDLE) && !ap_start;
    assign ap_return = ap_return_q;

    // State register and pipeline registers, each loaded in its own state.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            zsign_q     <= 1'b0;
            spec_q      <= 1'b0;
            spec_val_q  <= '0;
            zsig_q      <= '0;
            zexp_q      <= '0;
            zsgn_q      <= 1'b0;
            ap_return_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && ap_start) begin
                a_q     <= a;
                b_q     <= b;
                zsign_q <= zSign;
            end
            if (state_q == S_1) begin
                spec_q     <= s1_spec;
                spec_val_q <= s1_val;
                zsig_q     <= s1_sig;
                zexp_q     <= s1_exp;
                zsgn_q     <= s1_sign;
            end
            if (state_q == S_2) begin
                ap_return_q <= ap_return_d;
            end
        end
    end

endmodule

// File: tb/tb_sub_float64_sigs.sv
// Directed bench for sub_float64_sigs: hand-computed vectors, handshake
// latency, back-to-back operation and reset abort.
module tb_sub_float64_sigs;

    logic        clk;
    logic        rst;
    logic        start;
    logic        done, idle, ready;
    logic [63:0] a_in, b_in, ret;
    logic        zs;
    logic [21:0] key;

    int          n_tests;
    int          n_fail;
    logic [63:0] exp_q[$];

    sub_float64_sigs dut (
        .ap_clk      (clk),
        .ap_rst      (rst),
        .ap_start    (start),
        .ap_done     (done),
        .ap_idle     (idle),
        .ap_ready    (ready),
        .a           (a_in),
        .b           (b_in),
        .zSign       (zs),
        .ap_return   (ret),
        .working_key (key)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global time limit
    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "time limit");
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_tests++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, expv);
        end
    endtask

    // Drive one request, hold start until done, check latency/result/hold.
    task automatic run_op(input logic [63:0] av, input logic [63:0] bv, input logic zv,
                          input logic [63:0] ev, input string tag);
        int   cycles;
        logic seen;
        logic [63:0] e;
        @(negedge clk);
        a_in  = av;
        b_in  = bv;
        zs    = zv;
        start = 1'b1;
        exp_q.push_back(ev);
        cycles = 0;
        seen   = 1'b0;
        while (!seen && cycles < 20) begin
            @(posedge clk);
            #1;
            cycles++;
            if (cycles == 1) begin
                a_in = {$urandom, $urandom};
                b_in = {$urandom, $urandom};
                zs   = 1'($urandom_range(0, 1));
            end
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        e = exp_q.pop_front();
        if (!seen) begin
            check_val({tag, "_timeout"}, 64'd0, 64'd1);
        end else begin
            check_val({tag, "_lat"}, 64'(cycles), 64'd3);
            check_val({tag, "_ready"}, {63'd0, ready}, 64'd1);
            check_val(tag, ret, e);
            @(posedge clk);
            #1;
            check_val({tag, "_pulse"}, {63'd0, done}, 64'd0);
            check_val({tag, "_hold"}, ret, e);
        end
    endtask

    initial begin
        int   cyc;
        int   ndone;
        int   dcyc[2];
        logic [63:0] e;
        n_tests = 0;
        n_fail  = 0;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        zs    = 1'b0;
        key   = '0;
        rst   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_val("rst_idle", {63'd0, idle}, 64'd1);
        check_val("rst_ret", ret, 64'd0);
        check_val("rst_done", {63'd0, done}, 64'd0);
        check_val("rst_ready", {63'd0, ready}, 64'd0);

        run_op(64'h4000000000000000, 64'h3FF0000000000000, 1'b0, 64'h3FF0000000000000, "two_m_one");
        run_op(64'h3FF0000000000000, 64'h4000000000000000, 1'b0, 64'hBFF0000000000000, "one_m_two");
        run_op(64'h4000000000000000, 64'h3FF0000000000000, 1'b1, 64'hBFF0000000000000, "zsign_flip");
        run_op(64'h3FF8000000000000, 64'h3FF8000000000000, 1'b1, 64'h0000000000000000, "equal");
        run_op(64'hBFF0000000000000, 64'h3FF0000000000000, 1'b0, 64'h0000000000000000, "sign_ignored");
        run_op(64'h3FF0000000000000, 64'h3C90000000000000, 1'b0, 64'h3FF0000000000000, "tie_even");
        run_op(64'h3FF0000000000000, 64'h3CA0000000000000, 1'b0, 64'h3FEFFFFFFFFFFFFF, "round_down");
        run_op(64'h7FEFFFFFFFFFFFFF, 64'h0000000000000001, 1'b0, 64'h7FEFFFFFFFFFFFFF, "max_m_tiny");
        run_op(64'h7FF0000000000000, 64'h7FF0000000000000, 1'b0, 64'h7FFFFFFFFFFFFFFF, "inf_m_inf");
        run_op(64'h7FF0000000000000, 64'h3FF0000000000000, 1'b0, 64'h7FF0000000000000, "inf_m_one");
        run_op(64'h7FF0000000000001, 64'h3FF0000000000000, 1'b0, 64'h7FF8000000000001, "nan_a");
        run_op(64'h3FF0000000000000, 64'h7FF0000000000001, 1'b0, 64'h7FF8000000000001, "nan_b");
        run_op(64'h7FF0000000000002, 64'h7FF0000000000000, 1'b0, 64'h7FF8000000000002, "nan_eq_exp");
        run_op(64'h3FF0000000000000, 64'h7FF0000000000000, 1'b0, 64'hFFF0000000000000, "one_m_inf");
        run_op(64'h0000000000000003, 64'h0000000000000001, 1'b0, 64'h0000000000000002, "subnorm");
        run_op(64'h0010000000000000, 64'h0000000000000001, 1'b0, 64'h000FFFFFFFFFFFFF, "min_norm_m_sub");

        // Back-to-back: start held high, second operands presented mid-flight.
        @(negedge clk);
        a_in  = 64'h4000000000000000;
        b_in  = 64'h3FF0000000000000;
        zs    = 1'b0;
        start = 1'b1;
        exp_q.push_back(64'h3FF0000000000000);
        exp_q.push_back(64'hBFF0000000000000);
        cyc   = 0;
        ndone = 0;
        dcyc[0] = 0;
        dcyc[1] = 0;
        while (ndone < 2 && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 1) begin
                a_in = 64'h3FF0000000000000;
                b_in = 64'h4000000000000000;
            end
            if (done) begin
                dcyc[ndone] = cyc;
                e = exp_q.pop_front();
                check_val("b2b_ret", ret, e);
                ndone++;
                if (ndone == 2) start = 1'b0;
            end
        end
        start = 1'b0;
        check_val("b2b_count", 64'(ndone), 64'd2);
        check_val("b2b_first", 64'(dcyc[0]), 64'd3);
        check_val("b2b_second", 64'(dcyc[1]), 64'd7);
        exp_q.delete();

        // Reset asserted while in S2 aborts the operation.
        @(negedge clk);
        a_in  = 64'h4000000000000000;
        b_in  = 64'h3FF0000000000000;
        start = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst   = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;
        check_val("abort_done", {63'd0, done}, 64'd0);
        check_val("abort_idle", {63'd0, idle}, 64'd1);
        check_val("abort_ret", ret, 64'd0);
        rst   = 1'b0;
        ndone = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        check_val("abort_no_pulse", 64'(ndone), 64'd0);
        check_val("abort_idle_after", {63'd0, idle}, 64'd1);

        run_op(64'h3FF0000000000000, 64'h4000000000000000, 1'b0, 64'hBFF0000000000000, "after_abort");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sub_float64_sigs.md
# sub_float64_sigs

Multi-cycle IEEE-754 binary64 significand subtractor: returns |a| − |b| packed as a double whose sign is `zSign`, flipped when |b| > |a|. This is the same-sign subtract path of the soft-float library. It sits under the float64 subtract test top and is fed from the 22-entry × 64-bit operand ROMs. Those ROMs have a 1-cycle registered read gated by `ce0`. Control uses the standard start/done/idle/ready block handshake.

## Interface
- No parameters.
- `ap_clk` in 1: single clock; all state updates on rising edge.
- `ap_rst` in 1: reset, synchronous and active-high.
- `ap_start` in 1: request; held high by the caller until `ap_ready`.
- `ap_done` out 1: one-cycle pulse; `ap_return` is valid in this cycle.
- `ap_idle` out 1: high while in idle and `ap_start` is low.
- `ap_ready` out 1: one-cycle pulse, coincident with `ap_done`.
- `a` in 64: minuend, raw binary64 bits; sampled in the start cycle.
- `b` in 64: subtrahend, raw binary64 bits; sampled in the start cycle.
- `zSign` in 1: sign of a positive difference; sampled in the start cycle.
- `ap_return` out 64: result bits.
- `working_key` in 22: locking key. Results are specified only for `working_key = 22'd0`; other values need not give correct results.

## Operation
- Fields: sign is ignored; exp = bits[62:52]; frac = bits[51:0]. Set aSig = frac_a<<10 and bSig = frac_b<<10 (64-bit). expDiff = aExp − bExp (signed).
- **expDiff > 0:**
  - If aExp = 0x7FF: return propagateNaN(a,b) when aSig ≠ 0, else return `a`.
  - bSig |= 2^62 if bExp ≠ 0, else expDiff −= 1.
  - bSig = shiftRightJamming(bSig, expDiff). aSig |= 2^62.
  - zSig = aSig − bSig; zExp = aExp.
- **expDiff < 0:**
  - If bExp = 0x7FF: return propagateNaN when bSig ≠ 0, else return {~zSign, 0x7FF, 0}.
  - aSig |= 2^62 if aExp ≠ 0, else expDiff += 1.
  - aSig = shiftRightJamming(aSig, −expDiff). bSig |= 2^62.
  - zSig = bSig − aSig; zExp = bExp; sign = ~zSign.
- **expDiff = 0:**
  - If exp = 0x7FF: return propagateNaN when aSig|bSig ≠ 0, else return the default NaN 0x7FFF_FFFF_FFFF_FFFF.
  - If exp = 0, treat both exponents as 1.
  - aSig > bSig → subtract as in the expDiff > 0 case (no implicit bits added). bSig > aSig → as in the expDiff < 0 case. Equal → return 0x0 (+0).
- **shiftRightJamming(x,n):** n = 0 → x. n < 64 → (x>>n) | (any shifted-out bit). n ≥ 64 → (x ≠ 0).
- **Normalize:** zExp −= 1. s = clz64(zSig) − 1. zSig <<= s; zExp −= s.
- **Round, nearest-even only:** roundBits = zSig[9:0].
  - Overflow: if zExp > 0x7FD, or zExp = 0x7FD and zSig + 0x200 overflows bit 63, return {sign, 0x7FF, 0}.
  - Underflow: if zExp < 0, zSig = shiftRightJamming(zSig, −zExp) and zExp = 0.
  - zSig = (zSig + 0x200) >> 10. Clear bit 0 if roundBits = 0x200. If zSig = 0, zExp = 0.
  - Result = (sign<<63) + (zExp<<52) + zSig. This is an addition, so a mantissa carry increments the exponent.
- **propagateNaN:**
  - Quiet both operands: a' = a | 2^51, b' = b | 2^51.
  - Return b' if b is NaN, else a'.
- Exception flags are not produced.

## Timing
- States: IDLE → S1 → S2 → S3 (done) → IDLE.
- In IDLE with `ap_start` = 1, the block latches `a`, `b`, `zSign` and moves to S1.
- `ap_done` = `ap_ready` = 1 combinationally in S3, exactly 3 cycles after the start edge. They are low in every other cycle.
- `ap_return` is registered. It is valid from the S3 cycle and holds until the next completion.
- If `ap_start` is still high in the cycle after S3, a new operation begins, with no gap cycle required.
- Inputs that change outside the start cycle are ignored.
- Reset, including mid-operation: go to IDLE, `ap_done` = `ap_ready` = 0, `ap_return` = 0, no done pulse for the aborted operation. `ap_idle` = 1 whenever `ap_start` = 0.

## Test plan
- a=0x4000000000000000, b=0x3FF0000000000000, zSign=0 → 0x3FF0000000000000. `ap_done` pulses once, 3 cycles after start.
- a=0x3FF0000000000000, b=0x4000000000000000, zSign=0 → 0xBFF0000000000000. a=b=0x3FF8000000000000, zSign=1 → 0x0000000000000000.
- Rounding ties to even: a=0x3FF0000000000000, b=0x3C90000000000000 → 0x3FF0000000000000. With b=0x3CA0000000000000 → 0x3FEFFFFFFFFFFFFF.
- Specials:
  - a=b=0x7FF0000000000000 → 0x7FFFFFFFFFFFFFFF.
  - a=0x7FF0000000000000, b=0x3FF0000000000000 → 0x7FF0000000000000.
  - a=0x7FF0000000000001, b=0x3FF0000000000000 → 0x7FF8000000000001.
  - a=0x3FF0000000000000, b=0x7FF0000000000000, zSign=0 → 0xFFF0000000000000.
- Subnormals: a=0x0000000000000003, b=0x0000000000000001 → 0x0000000000000002. a=0x0010000000000000, b=0x0000000000000001 → 0x000FFFFFFFFFFFFF.
- Handshake and reset:
  - After reset, `ap_idle` = 1 and `ap_return` = 0.
  - Holding `ap_start` high gives back-to-back done pulses every 4 cycles.
  - Asserting `ap_rst` in S2 gives IDLE with no `ap_done`.
